// File: rtl/rst_seq_ctrl_if.sv
// Board-level reset sequencer bundle: restart inputs, per-channel ready in,
// per-channel resets and status out.
interface rst_seq_ctrl_if #(
    parameter int NUM_CH = 3
);
    logic              btn_n;
    logic              soft_rst_req;
    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] ch_rst_n;
    logic              all_done;
    logic              busy;
    logic [NUM_CH-1:0] timeout_err;
    logic [7:0]        cur_ch;
    logic [2:0]        state_dbg;

    modport master (
        output btn_n, soft_rst_req, ch_ready,
        input  ch_rst_n, all_done, busy, timeout_err, cur_ch, state_dbg
    );

    modport slave (
        input  btn_n, soft_rst_req, ch_ready,
        output ch_rst_n, all_done, busy, timeout_err, cur_ch, state_dbg
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset sequencer: power-on hold, then per-channel release with a
// fixed gap and a ready handshake; restartable from a debounced button or soft request.
module rst_seq_ctrl #(
    parameter int NUM_CH         = 3,
    parameter int CNT_W          = 21,
    parameter int POR_CYCLES     = 1048576,
    parameter int HOLD_CYCLES    = 4096,
    parameter int STAGE_CYCLES   = 254,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int DEB_CYCLES     = 65536
) (
    input  logic           clk_125,
    input  logic           rstn,
    rst_seq_ctrl_if.slave  bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  CH_ONE       = CH_W'(1);
    localparam logic [CH_W-1:0]  CH_ZERO      = {CH_W{1'b0}};

    if ((NUM_CH < 1) || (NUM_CH > 256)) begin : g_bad_num_ch
        $error("rst_seq_ctrl: NUM_CH must be in 1..256");
    end
    if ((64'(POR_CYCLES) > (64'd1 << CNT_W)) || (64'(HOLD_CYCLES) > (64'd1 << CNT_W)) ||
        (64'(STAGE_CYCLES) > (64'd1 << CNT_W)) || (64'(TIMEOUT_CYCLES) > (64'd1 << CNT_W)) ||
        (64'(DEB_CYCLES) > (64'd1 << CNT_W))) begin : g_bad_cycles
        $error("rst_seq_ctrl: a *_CYCLES value does not fit the CNT_W counter");
    end

    typedef enum logic [2:0] {
        ST_POR  = 3'd0,
        ST_HOLD = 3'd1,
        ST_GAP  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [CH_W-1:0]   cur_ch_r, cur_ch_nxt_s;
    logic [NUM_CH-1:0] ch_rst_n_r, ch_rst_n_nxt_s;
    logic [NUM_CH-1:0] timeout_err_r, timeout_err_nxt_s;
    logic              all_done_r, all_done_nxt_s;
    logic              busy_r;
    logic              btn_meta_r, btn_sync_r;
    logic [NUM_CH-1:0] rdy_meta_r, rdy_sync_r;
    logic [CNT_W-1:0]  deb_cnt_r, deb_cnt_nxt_s;
    logic              deb_low_r, deb_low_nxt_s;
    logic              btn_req_s;
    logic              restart_s;
    logic [7:0]        cur_ch_ext_s;

    // Two-flop synchronisers for the asynchronous button and ready inputs
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
            rdy_meta_r <= {NUM_CH{1'b0}};
            rdy_sync_r <= {NUM_CH{1'b0}};
        end else begin
            btn_meta_r <= bus.btn_n;
            btn_sync_r <= btn_meta_r;
            rdy_meta_r <= bus.ch_ready;
            rdy_sync_r <= rdy_meta_r;
        end
    end

    // Debouncer: the debounced level flips only after DEB_CYCLES agreeing samples
    always_comb begin
        deb_cnt_nxt_s = deb_cnt_r;
        deb_low_nxt_s = deb_low_r;
        btn_req_s     = 1'b0;
        if ((!btn_sync_r) != deb_low_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_low_nxt_s = !btn_sync_r;
                deb_cnt_nxt_s = CNT_ZERO;
                btn_req_s     = !btn_sync_r;
            end else begin
                deb_cnt_nxt_s = deb_cnt_r + CNT_ONE;
            end
        end else begin
            deb_cnt_nxt_s = CNT_ZERO;
        end
    end

    // Debouncer state register
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            deb_cnt_r <= CNT_ZERO;
            deb_low_r <= 1'b0;
        end else begin
            deb_cnt_r <= deb_cnt_nxt_s;
            deb_low_r <= deb_low_nxt_s;
        end
    end

    assign restart_s = bus.soft_rst_req | btn_req_s;
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // Sequencer next state and next registered outputs; a restart outranks WAIT completion
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_inc_s;
        cur_ch_nxt_s      = cur_ch_r;
        ch_rst_n_nxt_s    = ch_rst_n_r;
        timeout_err_nxt_s = timeout_err_r;
        all_done_nxt_s    = all_done_r;
        if (restart_s && (state_r == ST_GAP || state_r == ST_WAIT || state_r == ST_DONE)) begin
            state_nxt_s       = ST_HOLD;
            cnt_nxt_s         = CNT_ZERO;
            cur_ch_nxt_s      = CH_ZERO;
            ch_rst_n_nxt_s    = {NUM_CH{1'b0}};
            timeout_err_nxt_s = {NUM_CH{1'b0}};
            all_done_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ST_POR: begin
                    if (cnt_r == POR_LAST) begin
                        state_nxt_s  = ST_GAP;
                        cnt_nxt_s    = CNT_ZERO;
                        cur_ch_nxt_s = CH_ZERO;
                    end else begin
                        state_nxt_s = ST_POR;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_nxt_s  = ST_GAP;
                        cnt_nxt_s    = CNT_ZERO;
                        cur_ch_nxt_s = CH_ZERO;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == STAGE_LAST) begin
                        ch_rst_n_nxt_s[cur_ch_r] = 1'b1;
                        state_nxt_s              = ST_WAIT;
                        cnt_nxt_s                = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end
                ST_WAIT: begin
                    if (rdy_sync_r[cur_ch_r] || (cnt_r == TIMEOUT_LAST)) begin
                        if (!rdy_sync_r[cur_ch_r]) begin
                            timeout_err_nxt_s[cur_ch_r] = 1'b1;
                        end else begin
                            timeout_err_nxt_s[cur_ch_r] = timeout_err_r[cur_ch_r];
                        end
                        if (cur_ch_r == LAST_CH) begin
                            state_nxt_s    = ST_DONE;
                            all_done_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s  = ST_GAP;
                            cur_ch_nxt_s = cur_ch_r + CH_ONE;
                            cnt_nxt_s    = CNT_ZERO;
                        end
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s    = ST_POR;
                    cnt_nxt_s      = CNT_ZERO;
                    cur_ch_nxt_s   = CH_ZERO;
                    ch_rst_n_nxt_s = {NUM_CH{1'b0}};
                    all_done_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_POR;
            cnt_r         <= CNT_ZERO;
            cur_ch_r      <= CH_ZERO;
            ch_rst_n_r    <= {NUM_CH{1'b0}};
            timeout_err_r <= {NUM_CH{1'b0}};
            all_done_r    <= 1'b0;
            busy_r        <= 1'b1;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            cur_ch_r      <= cur_ch_nxt_s;
            ch_rst_n_r    <= ch_rst_n_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
            all_done_r    <= all_done_nxt_s;
            busy_r        <= (state_nxt_s != ST_DONE);
        end
    end

    // Zero-extend the channel index onto the fixed 8-bit debug port
    always_comb begin
        cur_ch_ext_s               = 8'd0;
        cur_ch_ext_s[CH_W-1:0]     = cur_ch_r;
    end

    assign bus.ch_rst_n    = ch_rst_n_r;
    assign bus.all_done    = all_done_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.cur_ch      = cur_ch_ext_s;
    assign bus.state_dbg   = state_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with short cycle parameters; edge numbers are
// counted from the first rising edge after rstn is released.
module tb_rst_seq_ctrl;

    logic clk_125;
    logic rstn;

    rst_seq_ctrl_if #(.NUM_CH(3)) bus ();

    rst_seq_ctrl #(
        .NUM_CH(3), .CNT_W(21), .POR_CYCLES(16), .HOLD_CYCLES(8),
        .STAGE_CYCLES(4), .TIMEOUT_CYCLES(10), .DEB_CYCLES(3)
    ) dut (
        .clk_125 (clk_125),
        .rstn    (rstn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;
    int rise_ch[3];
    int rise_done = -1;
    int rise_err1 = -1;
    int hold_entries = 0;
    logic [2:0] prev_rst;
    logic       prev_done;
    logic       prev_err1;
    logic [2:0] prev_state;
    int e_base;

    initial clk_125 = 1'b0;
    always #4 clk_125 = ~clk_125;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // One clock edge, sampled 1 ns later; latest rise edges are recorded
    task automatic tick();
        @(posedge clk_125);
        #1;
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            if (bus.ch_rst_n[i] && !prev_rst[i]) rise_ch[i] = edge_n;
        end
        if (bus.all_done && !prev_done) rise_done = edge_n;
        if (bus.timeout_err[1] && !prev_err1) rise_err1 = edge_n;
        if ((bus.state_dbg == 3'd1) && (prev_state != 3'd1)) hold_entries++;
        prev_rst   = bus.ch_rst_n;
        prev_done  = bus.all_done;
        prev_err1  = bus.timeout_err[1];
        prev_state = bus.state_dbg;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) rise_ch[i] = -1;
        rstn             = 1'b0;
        bus.btn_n        = 1'b1;
        bus.soft_rst_req = 1'b0;
        bus.ch_ready     = 3'b111;
        #19;
        check_eq("rst_ch_rst_n", 32'(bus.ch_rst_n), 32'd0);
        check_eq("rst_all_done", 32'(bus.all_done), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd1);
        check_eq("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        check_eq("rst_state", 32'(bus.state_dbg), 32'd0);
        check_eq("rst_cur_ch", 32'(bus.cur_ch), 32'd0);
        prev_rst   = bus.ch_rst_n;
        prev_done  = bus.all_done;
        prev_err1  = bus.timeout_err[1];
        prev_state = bus.state_dbg;
        @(negedge clk_125);
        rstn = 1'b1;

        // Power-on sequence, soft request during POR must be ignored
        run_to(4);
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        run_to(15);
        check_eq("por_state_e15", 32'(bus.state_dbg), 32'd0);
        tick();
        check_eq("gap_state_e16", 32'(bus.state_dbg), 32'd2);
        run_to(34);
        check_eq("t1_rise_ch0", 32'(rise_ch[0]), 32'd20);
        check_eq("t1_rise_ch1", 32'(rise_ch[1]), 32'd25);
        check_eq("t1_rise_ch2", 32'(rise_ch[2]), 32'd30);
        check_eq("t1_rise_done", 32'(rise_done), 32'd31);
        check_eq("t1_timeout_err", 32'(bus.timeout_err), 32'd0);
        check_eq("t1_busy", 32'(bus.busy), 32'd0);
        check_eq("t1_state", 32'(bus.state_dbg), 32'd4);
        check_eq("t1_ch_rst_n", 32'(bus.ch_rst_n), 32'd7);
        check_eq("t1_hold_entries", 32'(hold_entries), 32'd0);

        // Short button glitch in DONE must not restart
        bus.btn_n = 1'b0;
        tick();
        tick();
        bus.btn_n = 1'b1;
        run_to(edge_n + 6);
        check_eq("t3_glitch_state", 32'(bus.state_dbg), 32'd4);
        check_eq("t3_glitch_holds", 32'(hold_entries), 32'd0);

        // Real press: one HOLD entry, soft request inside HOLD ignored
        e_base = edge_n;
        bus.btn_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            bus.soft_rst_req = (k == 8);
            tick();
            if (edge_n == e_base + 5) begin
                check_eq("t3_hold_state", 32'(bus.state_dbg), 32'd1);
                check_eq("t3_hold_ch_rst_n", 32'(bus.ch_rst_n), 32'd0);
                check_eq("t3_hold_all_done", 32'(bus.all_done), 32'd0);
            end
        end
        bus.soft_rst_req = 1'b0;
        bus.btn_n = 1'b1;
        run_to(e_base + 30);
        check_eq("t3_hold_entries", 32'(hold_entries), 32'd1);
        check_eq("t3_rise_ch0", 32'(rise_ch[0]), 32'(e_base + 17));
        check_eq("t3_rise_ch1", 32'(rise_ch[1]), 32'(e_base + 22));
        check_eq("t3_rise_ch2", 32'(rise_ch[2]), 32'(e_base + 27));
        check_eq("t3_rise_done", 32'(rise_done), 32'(e_base + 28));

        // Channel 1 never ready: timeout, then continue to channel 2
        e_base = edge_n;
        bus.ch_ready = 3'b101;
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        check_eq("t2_hold_state", 32'(bus.state_dbg), 32'd1);
        check_eq("t2_hold_ch_rst_n", 32'(bus.ch_rst_n), 32'd0);
        run_to(e_base + 35);
        check_eq("t2_rise_ch1", 32'(rise_ch[1]), 32'(e_base + 18));
        check_eq("t2_rise_err1", 32'(rise_err1), 32'(e_base + 28));
        check_eq("t2_rise_ch2", 32'(rise_ch[2]), 32'(e_base + 32));
        check_eq("t2_rise_done", 32'(rise_done), 32'(e_base + 33));
        check_eq("t2_timeout_err", 32'(bus.timeout_err), 32'd2);
        check_eq("t2_ch_rst_n", 32'(bus.ch_rst_n), 32'd7);

        // Soft request collides with channel 1 ready arriving in WAIT
        e_base = edge_n;
        bus.ch_ready = 3'b001;
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        check_eq("t4_err_cleared", 32'(bus.timeout_err), 32'd0);
        run_to(e_base + 19);
        bus.ch_ready = 3'b011;
        run_to(e_base + 21);
        check_eq("t4_wait_state", 32'(bus.state_dbg), 32'd3);
        check_eq("t4_wait_cur_ch", 32'(bus.cur_ch), 32'd1);
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        check_eq("t4_hold_state", 32'(bus.state_dbg), 32'd1);
        check_eq("t4_ch_rst_n", 32'(bus.ch_rst_n), 32'd0);
        check_eq("t4_cur_ch", 32'(bus.cur_ch), 32'd0);
        check_eq("t4_timeout_err", 32'(bus.timeout_err), 32'd0);

        // Asynchronous rstn while waiting on channel 2
        e_base = edge_n;
        run_to(e_base + 23);
        check_eq("t6_wait_state", 32'(bus.state_dbg), 32'd3);
        check_eq("t6_wait_cur_ch", 32'(bus.cur_ch), 32'd2);
        check_eq("t6_wait_ch_rst_n", 32'(bus.ch_rst_n), 32'd7);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("t6_ch_rst_n", 32'(bus.ch_rst_n), 32'd0);
        check_eq("t6_busy", 32'(bus.busy), 32'd1);
        check_eq("t6_state", 32'(bus.state_dbg), 32'd0);
        check_eq("t6_cur_ch", 32'(bus.cur_ch), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
